// File: rtl/eth_f_hw_avmm_pkg.sv
// Shared types for the HW-client AVMM request fanout.
// FSM states, request op codes and default select geometry.
package eth_f_hw_avmm_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_SEL_LSB    = 12;
  localparam int SEL_W          = DEF_ADDR_WIDTH - DEF_SEL_LSB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD,
    ST_WR_WAIT
  } state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

endpackage

// File: rtl/eth_f_hw_avmm_addr_decode.sv
// Client index decode from the upper host address bits.
// Produces the raw index, a one-hot client vector and a mapped flag.
module eth_f_hw_avmm_addr_decode
  import eth_f_hw_avmm_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int SEL_LSB     = DEF_SEL_LSB,
  parameter int NUM_CLIENTS = 2,
  localparam int SelW       = ADDR_WIDTH - SEL_LSB
) (
  input  logic [ADDR_WIDTH-1:0]  address,
  output logic [SelW-1:0]        sel,
  output logic [NUM_CLIENTS-1:0] onehot,
  output logic                   mapped
);

  logic unused_lo;

  assign sel       = address[ADDR_WIDTH-1:SEL_LSB];
  assign mapped    = 32'(sel) < 32'(NUM_CLIENTS);
  assign unused_lo = ^address[SEL_LSB-1:0];

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      onehot[i] = (32'(sel) == 32'(i));
    end
  end

endmodule

// File: rtl/eth_f_hw_avmm_req_fanout.sv
// Host AVMM request stage: one transaction at a time, strobes to one client.
// Optional decode-error counters under ETH_F_HW_AVMM_DECERR_EN.
module eth_f_hw_avmm_req_fanout
  import eth_f_hw_avmm_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DAT_WIDTH   = 32,
  parameter int NUM_CLIENTS = 2,
  parameter int SEL_LSB     = 12,
  parameter int WR_HOLD     = 2
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [ADDR_WIDTH-1:0]  host_address,
  input  logic                   host_read,
  input  logic                   host_write,
  input  logic [DAT_WIDTH-1:0]   host_writedata,
  output logic                   host_waitrequest,
  output logic [ADDR_WIDTH-1:0]  client_address,
  output logic [DAT_WIDTH-1:0]   client_writedata,
  output logic [NUM_CLIENTS-1:0] client_read,
  output logic [NUM_CLIENTS-1:0] client_write,
  output logic                   rdcomb_read,
  input  logic                   rdcomb_waitrequest
`ifdef ETH_F_HW_AVMM_DECERR_EN
  ,
  output logic [15:0]            decerr_count,
  output logic [ADDR_WIDTH-1:0]  decerr_addr
`endif
);

  localparam int SelW  = ADDR_WIDTH - SEL_LSB;
  localparam int HoldW = $clog2(WR_HOLD + 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(WR_HOLD - 1);

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [NUM_CLIENTS-1:0] onehot_q, onehot_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DAT_WIDTH-1:0]   wdata_q, wdata_d;
  logic [HoldW-1:0]       hold_q, hold_d;
  logic                   first_q, first_d;

  logic [SelW-1:0]        sel_unused;
  logic [NUM_CLIENTS-1:0] dec_onehot;
  logic                   dec_mapped;
  logic                   accept;

  eth_f_hw_avmm_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SEL_LSB    (SEL_LSB),
    .NUM_CLIENTS(NUM_CLIENTS)
  ) u_dec (
    .address(host_address),
    .sel    (sel_unused),
    .onehot (dec_onehot),
    .mapped (dec_mapped)
  );

  assign accept = (state_q == ST_IDLE)
                & (host_read | host_write);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    onehot_d     = onehot_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    hold_d       = hold_q;
    first_d      = first_q;
    client_read  = '0;
    client_write = '0;
    rdcomb_read  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // read wins when both requests arrive together
          op_d     = host_read ? OP_RD : OP_WR;
          addr_d   = host_address;
          wdata_d  = host_writedata;
          onehot_d = dec_onehot;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (op_q == OP_RD) begin
          client_read = onehot_q;
          rdcomb_read = 1'b1;
          first_d     = 1'b1;
          state_d     = ST_WAIT_RD;
        end else begin
          client_write = onehot_q;
          hold_d       = HoldLoad;
          state_d      = ST_WR_WAIT;
        end
      end
      ST_WAIT_RD: begin
        // combiner flag is not valid yet on the first cycle
        if (first_q) begin
          first_d = 1'b0;
        end else if (!rdcomb_waitrequest) begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_WAIT: begin
        if (hold_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - HoldW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_RD;
      onehot_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hold_q   <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      onehot_q <= onehot_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hold_q   <= hold_d;
      first_q  <= first_d;
    end
  end

  assign host_waitrequest = (state_q != ST_IDLE);
  assign client_address   = addr_q;
  assign client_writedata = wdata_q;

`ifdef ETH_F_HW_AVMM_DECERR_EN
  logic [15:0]           derr_cnt_q, derr_cnt_d;
  logic [ADDR_WIDTH-1:0] derr_addr_q, derr_addr_d;

  always_comb begin
    derr_cnt_d  = derr_cnt_q;
    derr_addr_d = derr_addr_q;
    if (accept && !dec_mapped) begin
      derr_addr_d = host_address;
      if (derr_cnt_q != 16'hFFFF) begin
        derr_cnt_d = derr_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      derr_cnt_q  <= '0;
      derr_addr_q <= '0;
    end else begin
      derr_cnt_q  <= derr_cnt_d;
      derr_addr_q <= derr_addr_d;
    end
  end

  assign decerr_count = derr_cnt_q;
  assign decerr_addr  = derr_addr_q;
`else
  logic unused_mapped;
  assign unused_mapped = dec_mapped;
`endif

endmodule

// File: tb/tb_eth_f_hw_avmm_req_fanout.sv
// Scoreboard bench for eth_f_hw_avmm_req_fanout with a read-combiner model.
// Honours ETH_F_HW_AVMM_DECERR_EN for the decode-error outputs.
module tb_eth_f_hw_avmm_req_fanout;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int NC  = 2;
  localparam int WRH = 2;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic [AW-1:0] host_address = '0;
  logic          host_read = 1'b0;
  logic          host_write = 1'b0;
  logic [DW-1:0] host_writedata = '0;
  logic          host_waitrequest;
  logic [AW-1:0] client_address;
  logic [DW-1:0] client_writedata;
  logic [NC-1:0] client_read;
  logic [NC-1:0] client_write;
  logic          rdcomb_read;
  logic          rdcomb_waitrequest = 1'b0;
`ifdef ETH_F_HW_AVMM_DECERR_EN
  logic [15:0]   decerr_count;
  logic [AW-1:0] decerr_addr;
`endif

  eth_f_hw_avmm_req_fanout #(
    .ADDR_WIDTH (AW),
    .DAT_WIDTH  (DW),
    .NUM_CLIENTS(NC),
    .SEL_LSB    (12),
    .WR_HOLD    (WRH)
  ) dut (
    .clk               (clk),
    .arst              (arst),
    .host_address      (host_address),
    .host_read         (host_read),
    .host_write        (host_write),
    .host_writedata    (host_writedata),
    .host_waitrequest  (host_waitrequest),
    .client_address    (client_address),
    .client_writedata  (client_writedata),
    .client_read       (client_read),
    .client_write      (client_write),
    .rdcomb_read       (rdcomb_read),
    .rdcomb_waitrequest(rdcomb_waitrequest)
`ifdef ETH_F_HW_AVMM_DECERR_EN
    ,
    .decerr_count      (decerr_count),
    .decerr_addr       (decerr_addr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NC-1:0] cr;
    logic [NC-1:0] cw;
    logic          rc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } stb_t;

  stb_t stb_q[$];
  int   lat_q[$];
  int   busy_q[$];
  int   checks = 0;
  int   errors = 0;
  int   strobe_seen = 0;
`ifdef ETH_F_HW_AVMM_DECERR_EN
  int            m_derr_cnt = 0;
  logic [AW-1:0] m_derr_addr = '0;
`endif

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected effects of one accepted request, from the block's rules.
  task automatic push_txn(input bit rd, input bit wr,
                          input logic [AW-1:0] addr,
                          input logic [DW-1:0] data,
                          input int lat, input bit chk_busy);
    int   sel;
    bit   mapped;
    stb_t e;
    if (!rd && !wr) return;
    sel    = int'(addr[AW-1:12]);
    mapped = sel < NC;
    e.addr = addr;
    e.data = data;
    e.cr   = '0;
    e.cw   = '0;
    e.rc   = 1'b0;
    if (rd) begin
      if (mapped) e.cr[sel] = 1'b1;
      e.rc = 1'b1;
      stb_q.push_back(e);
      lat_q.push_back(lat);
      if (chk_busy) busy_q.push_back(lat + 1);
    end else begin
      if (mapped) begin
        e.cw[sel] = 1'b1;
        stb_q.push_back(e);
      end
      if (chk_busy) busy_q.push_back(1 + WRH);
    end
`ifdef ETH_F_HW_AVMM_DECERR_EN
    if (!mapped) begin
      if (m_derr_cnt < 65535) m_derr_cnt++;
      m_derr_addr = addr;
    end
`endif
  endtask

  task automatic chk_derr();
`ifdef ETH_F_HW_AVMM_DECERR_EN
    chk("decerr_count", decerr_count, 64'(m_derr_cnt));
    chk("decerr_addr", decerr_addr, 64'(m_derr_addr));
`endif
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (!host_waitrequest) done = 1;
      else begin
        @(posedge clk);
        #2;
      end
    end
    if (!done) chk("idle_timeout", host_waitrequest, 0);
  endtask

  task automatic issue(input bit rd, input bit wr,
                       input logic [AW-1:0] addr,
                       input logic [DW-1:0] data,
                       input int lat, input bit chk_busy);
    wait_idle();
    host_read      = rd;
    host_write     = wr;
    host_address   = addr;
    host_writedata = data;
    push_txn(rd, wr, addr, data, lat, chk_busy);
    @(posedge clk);
    #2;
    host_read  = 1'b0;
    host_write = 1'b0;
    chk_derr();
  endtask

  // Read combiner: pending flag stays high for lat cycles from the kick.
  int pend = 0;
  always @(negedge clk) begin
    if (arst) begin
      pend = 0;
    end else if (rdcomb_read) begin
      if (lat_q.size() == 0) begin
        chk("comb_unexp_kick", lat_q.size(), 1);
        pend = 2;
      end else begin
        pend = lat_q.pop_front();
      end
    end else if (pend > 0) begin
      pend--;
    end
    rdcomb_waitrequest = (pend > 0);
  end

  always @(negedge clk) begin
    stb_t e;
    if (!arst && (client_read != 0 || client_write != 0 || rdcomb_read)) begin
      strobe_seen++;
      if (stb_q.size() == 0) begin
        chk("stb_unexpected", stb_q.size(), 1);
      end else begin
        e = stb_q.pop_front();
        chk("client_read", client_read, e.cr);
        chk("client_write", client_write, e.cw);
        chk("rdcomb_read", rdcomb_read, e.rc);
        chk("client_address", client_address, e.addr);
        chk("client_writedata", client_writedata, e.data);
      end
    end
  end

  int busy_run = 0;
  always @(negedge clk) begin
    if (arst) begin
      busy_run = 0;
    end else if (host_waitrequest) begin
      busy_run++;
    end else if (busy_run > 0) begin
      if (busy_q.size() == 0) chk("busy_unexpected", busy_q.size(), 1);
      else chk("busy_cycles", busy_run, busy_q.pop_front());
      busy_run = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [3:0] sels [5];
    sels[0] = 4'd0; sels[1] = 4'd1; sels[2] = 4'd2;
    sels[3] = 4'd3; sels[4] = 4'd15;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_waitreq", host_waitrequest, 0);
    chk("rst_client_read", client_read, 0);
    chk("rst_client_write", client_write, 0);
    chk("rst_rdcomb_read", rdcomb_read, 0);
    chk("rst_client_address", client_address, 0);
    chk("rst_client_writedata", client_writedata, 0);
    chk_derr();
    arst = 1'b0;
    @(posedge clk);
    #2;

    issue(1, 0, 16'h1004, 32'h1111_2222, 3, 1);
    issue(0, 1, 16'h0010, 32'hCAFE_F00D, 0, 1);
    issue(1, 0, 16'h3000, 32'h0, 2, 1);
    wait_idle();
    chk_derr();
    issue(1, 1, 16'h1000, 32'h5A5A_5A5A, 4, 1);

    issue(1, 0, 16'h0123, 32'h0BAD_BEEF, 6, 0);
    @(posedge clk);
    #2;
    arst = 1'b1;
    #1;
    chk("arst_client_read", client_read, 0);
    chk("arst_client_write", client_write, 0);
    chk("arst_rdcomb_read", rdcomb_read, 0);
    chk("arst_waitreq", host_waitrequest, 0);
    chk("arst_client_address", client_address, 0);
`ifdef ETH_F_HW_AVMM_DECERR_EN
    m_derr_cnt  = 0;
    m_derr_addr = '0;
`endif
    @(posedge clk);
    #2;
    arst = 1'b0;
    chk_derr();
    issue(1, 0, 16'h1ABC, 32'h7777_0000, 3, 1);

    wait_idle();
    base         = strobe_seen;
    host_address = 16'h0040;
    host_read    = 1'b1;
    push_txn(1, 0, 16'h0040, host_writedata, 2, 1);
    push_txn(1, 0, 16'h0040, host_writedata, 3, 1);
    for (int i = 0; i < 100 && strobe_seen < base + 2; i++) begin
      @(posedge clk);
      #2;
    end
    host_read = 1'b0;
    chk("b2b_strobes", strobe_seen - base, 2);

    repeat (150) begin
      int k;
      bit rd, wr;
      logic [AW-1:0] a;
      k  = $urandom_range(0, 3);
      rd = (k != 1);
      wr = (k == 1 || k == 2);
      a  = {sels[$urandom_range(0, 4)], 12'($urandom)};
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #2;
      end
      issue(rd, wr, a, $urandom, $urandom_range(2, 6), 1);
    end

    wait_idle();
    repeat (10) @(posedge clk);
    #2;
    chk("stb_q_empty", stb_q.size(), 0);
    chk("lat_q_empty", lat_q.size(), 0);
    chk("busy_q_empty", busy_q.size(), 0);
    chk_derr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
